// File: rtl/spdif_frame_sequencer_if.sv
// rtl/spdif_frame_sequencer_if.sv - stereo sample pair handshake into the S/PDIF frame sequencer
interface spdif_frame_sequencer_if #(
    parameter int SAMPLE_W = 24
);
    logic [SAMPLE_W-1:0] sample_l;
    logic [SAMPLE_W-1:0] sample_r;
    logic                sample_valid;
    logic                sample_ready;
    logic                user_bit;
    logic                cs_bit;

    modport master (
        output sample_l, sample_r, sample_valid, user_bit, cs_bit,
        input  sample_ready
    );

    modport slave (
        input  sample_l, sample_r, sample_valid, user_bit, cs_bit,
        output sample_ready
    );
endinterface

// File: rtl/spdif_frame_sequencer.sv
// rtl/spdif_frame_sequencer.sv - S/PDIF subframe builder with preambles, parity and biphase-mark line
module spdif_frame_sequencer #(
    parameter int SAMPLE_W         = 24,
    parameter int FRAMES_PER_BLOCK = 192
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    spdif_frame_sequencer_if.slave  s_if,
    output logic [7:0]              frame_idx,
    output logic                    underrun,
    output logic                    spdif_out
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [7:0] PAT_B      = 8'b11101000;
    localparam logic [7:0] PAT_M      = 8'b11100010;
    localparam logic [7:0] PAT_W      = 8'b11100100;
    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);
    localparam int         PAD        = 24 - SAMPLE_W;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [5:0]          r_ui;
    logic                r_sub;
    logic [7:0]          r_frame;
    logic [SAMPLE_W-1:0] r_hl;
    logic [SAMPLE_W-1:0] r_hr;
    logic                r_u;
    logic                r_c;
    logic                r_v;
    logic                r_out;
    logic                r_lvl0;

    logic                w_end_sub;
    logic                w_ready;
    logic [23:0]         w_aud;
    logic                w_par;
    logic [31:0]         w_word;
    logic                w_bit;
    logic [7:0]          w_pat;
    logic [2:0]          w_pidx;
    logic                w_lvl;
    logic                w_line_nxt;

    assign w_end_sub = (r_state == S_DATA) && (r_ui == 6'd63);
    // reset gates ready so every output reads 0 while rst_n is low
    assign w_ready   = rst_n && enable && ((r_state == S_IDLE) || (w_end_sub && r_sub));

    assign s_if.sample_ready = w_ready;
    assign underrun          = w_ready && !s_if.sample_valid;
    assign frame_idx         = r_frame;
    assign spdif_out         = r_out;

    // left-justify the sample so its MSB always lands in slot 27
    assign w_aud  = 24'(r_sub ? r_hr : r_hl) << PAD;
    assign w_par  = ^{r_c, r_u, r_v, w_aud};
    assign w_word = {w_par, r_c, r_u, r_v, w_aud, 4'b0000};
    assign w_bit  = w_word[r_ui[5:1]];

    assign w_pat  = r_sub ? PAT_W : ((r_frame == 8'd0) ? PAT_B : PAT_M);
    assign w_pidx = 3'd7 - r_ui[2:0];
    assign w_lvl  = (r_ui == 6'd0) ? r_out : r_lvl0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_line_nxt  = r_out;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                w_line_nxt = w_pat[w_pidx] ^ w_lvl;
                if (r_ui == 6'd7) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                // biphase mark: transition at every cell start, mid-cell only for a 1
                w_line_nxt = r_ui[0] ? (r_out ^ w_bit) : ~r_out;
                if (w_end_sub) begin
                    w_state_nxt = (r_sub && !enable) ? S_IDLE : S_PRE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ui    <= 6'd0;
            r_sub   <= 1'b0;
            r_frame <= 8'd0;
            r_hl    <= '0;
            r_hr    <= '0;
            r_u     <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_out   <= 1'b0;
            r_lvl0  <= 1'b0;
        end else begin
            r_out <= w_line_nxt;
            if ((r_state == S_PRE) && (r_ui == 6'd0)) begin
                r_lvl0 <= r_out;
            end
            if (r_state == S_IDLE) begin
                r_ui <= 6'd0;
                if (enable) begin
                    r_sub   <= 1'b0;
                    r_frame <= 8'd0;
                end
            end else begin
                r_ui <= r_ui + 6'd1;
                if (r_ui == 6'd63) begin
                    r_sub <= ~r_sub;
                    if (r_sub) begin
                        r_frame <= (r_frame == LAST_FRAME) ? 8'd0 : r_frame + 8'd1;
                    end
                end
            end
            if (w_ready) begin
                if (s_if.sample_valid) begin
                    r_hl <= s_if.sample_l;
                    r_hr <= s_if.sample_r;
                    r_u  <= s_if.user_bit;
                    r_c  <= s_if.cs_bit;
                    r_v  <= 1'b0;
                end else begin
                    // underrun: repeat the held pair flagged invalid
                    r_u  <= 1'b0;
                    r_c  <= s_if.cs_bit;
                    r_v  <= 1'b1;
                end
            end
        end
    end
endmodule
